// File: rtl/pipe_skid_register.sv
// pipe_skid_register: two-entry in-order pipeline register with a skid slot.
// The main register drives out_data. The skid register absorbs one extra entry
// when downstream stalls. in_ready is registered, so there is no combinational
// path from out_ready to in_ready. An empty block shows FLUSH_VALUE (a bubble).
module pipe_skid_register #(
   parameter int                         NBits       = 32,
   parameter int                         NFields     = 2,
   parameter logic [NFields*NBits-1:0]   FLUSH_VALUE = '0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         in_valid,
   input  logic [NFields*NBits-1:0]     in_data,
   output logic                         in_ready,
   output logic                         out_valid,
   output logic [NFields*NBits-1:0]     out_data,
   input  logic                         out_ready,
   output logic [1:0]                   occupancy
);

   // The state encoding is the occupancy count, so occupancy can be read straight off it.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_e;

   state_e                      state_q, state_d;
   logic [NFields*NBits-1:0]    main_q, main_d;
   logic [NFields*NBits-1:0]    skid_q, skid_d;
   logic                        in_ready_q, in_ready_d;

   logic                        accept;
   logic                        pop;

   assign accept    = in_valid & in_ready_q;
   assign pop       = out_valid & out_ready;

   assign in_ready  = in_ready_q;
   assign out_valid = (state_q != EMPTY);
   assign out_data  = main_q;
   assign occupancy = state_q;

   // Next-state and datapath: flush wins over handshakes; otherwise walk the 0/1/2-entry FIFO.
   always_comb begin
      // NOTE: every signal gets a default before the branches, so no path leaves one unassigned (no latch).
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;

      if (flush) begin
         state_d = EMPTY;
         main_d  = FLUSH_VALUE;
         skid_d  = FLUSH_VALUE;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  state_d = ONE;
                  main_d  = in_data;
               end
            end
            ONE: begin
               if (accept && pop) begin
                  main_d  = in_data;
               end else if (accept) begin
                  state_d = FULL;
                  skid_d  = in_data;
               end else if (pop) begin
                  state_d = EMPTY;
                  main_d  = FLUSH_VALUE;
               end
            end
            FULL: begin
               if (pop) begin
                  state_d = ONE;
                  main_d  = skid_q;
               end
            end
            default: begin
               state_d = EMPTY;
               main_d  = FLUSH_VALUE;
               skid_d  = FLUSH_VALUE;
            end
         endcase
      end

      in_ready_d = (state_d != FULL);
   end

   // State and data registers with synchronous reset; reset overrides flush and handshakes.
   always_ff @(posedge clk) begin
      // NOTE: the data registers are reset as well, because an empty block must show FLUSH_VALUE.
      if (reset) begin
         state_q    <= EMPTY;
         main_q     <= FLUSH_VALUE;
         skid_q     <= FLUSH_VALUE;
         in_ready_q <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments, so every register samples the pre-edge values.
         state_q    <= state_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
         in_ready_q <= in_ready_d;
      end
   end

endmodule

// File: tb/tb_pipe_skid_register.sv
// Bench for pipe_skid_register: directed scenarios with literal expectations,
// then randomized valid/ready/flush/reset traffic checked against a reference queue.
module tb_pipe_skid_register;

   localparam int          NBITS   = 32;
   localparam int          NFIELDS = 2;
   localparam int          W       = NBITS * NFIELDS;
   localparam logic [W-1:0] FLUSH  = 64'hF1F1_0000_0000_F1F1;

   logic          clk;
   logic          reset;
   logic          flush;
   logic          in_valid;
   logic [W-1:0]  in_data;
   logic          in_ready;
   logic          out_valid;
   logic [W-1:0]  out_data;
   logic          out_ready;
   logic [1:0]    occupancy;

   int tests_run = 0;
   int tests_failed = 0;

   pipe_skid_register #(
      .NBits       (NBITS),
      .NFields     (NFIELDS),
      .FLUSH_VALUE (FLUSH)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .occupancy (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: an in-order queue holding at most two entries.
   logic [W-1:0] model_q[$];
   bit           model_defined = 1'b0;

   always @(posedge clk) begin
      bit acc;
      bit pp;
      if (reset) begin
         model_q.delete();
         model_defined = 1'b1;
      end else if (flush) begin
         model_q.delete();
      end else begin
         acc = in_valid && (model_q.size() < 2);
         pp  = (model_q.size() > 0) && out_ready;
         if (pp)  void'(model_q.pop_front());
         if (acc) model_q.push_back(in_data);
      end
   end

   // Compare process: check every output against the model on each falling edge.
   always @(negedge clk) begin
      if (model_defined) begin
         check("cmp_out_valid", W'(out_valid), W'(model_q.size() != 0));
         check("cmp_out_data",  out_data, (model_q.size() != 0) ? model_q[0] : FLUSH);
         check("cmp_occupancy", W'(occupancy), W'(model_q.size()));
         check("cmp_in_ready",  W'(in_ready), W'(model_q.size() < 2));
      end
   end

   // One clock cycle: drive the inputs, then wait until just after the rising edge.
   task automatic cyc(input logic v, input logic [W-1:0] d, input logic r,
                      input logic f, input logic rst);
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      flush     = f;
      reset     = rst;
      @(posedge clk);
      #1;
   endtask

   task automatic check_empty(input string tag);
      check({tag, "_out_valid"}, W'(out_valid), '0);
      check({tag, "_out_data"},  out_data, FLUSH);
      check({tag, "_occupancy"}, W'(occupancy), '0);
      check({tag, "_in_ready"},  W'(in_ready), W'(1));
   endtask

   localparam logic [W-1:0] A = 64'hAAAA_0001_AAAA_0001;
   localparam logic [W-1:0] B = 64'hBBBB_0002_BBBB_0002;
   localparam logic [W-1:0] C = 64'hCCCC_0003_CCCC_0003;

   initial begin
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      flush     = 1'b0;
      reset     = 1'b1;
      @(posedge clk);
      #1;

      // Reset state
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
      check_empty("reset");

      // First push after reset appears after one cycle
      cyc(1'b1, 64'h00000004_8C220000, 1'b1, 1'b0, 1'b0);
      check("first_valid", W'(out_valid), W'(1));
      check("first_data",  out_data, 64'h00000004_8C220000);
      check("first_occ",   W'(occupancy), W'(1));
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
      check_empty("first_drain");

      // Streaming at full rate
      for (int i = 1; i <= 4; i++) begin
         cyc(1'b1, W'(i), 1'b1, 1'b0, 1'b0);
         check("stream_data",  out_data, W'(i));
         check("stream_ready", W'(in_ready), W'(1));
         check("stream_occ",   W'(occupancy), W'(1));
      end
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
      check_empty("stream_drain");

      // Backpressure: A and B fill the block, C is refused
      cyc(1'b1, A, 1'b0, 1'b0, 1'b0);
      check("bp_a_data", out_data, A);
      cyc(1'b1, B, 1'b0, 1'b0, 1'b0);
      check("bp_full_occ",   W'(occupancy), W'(2));
      check("bp_full_ready", W'(in_ready), W'(0));
      check("bp_full_data",  out_data, A);
      cyc(1'b1, C, 1'b0, 1'b0, 1'b0);
      check("bp_stall_data", out_data, A);
      check("bp_stall_occ",  W'(occupancy), W'(2));
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
      check("bp_pop_data",  out_data, B);
      check("bp_pop_occ",   W'(occupancy), W'(1));
      check("bp_pop_ready", W'(in_ready), W'(1));
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
      check_empty("bp_drain");

      // Flush while full, with an entry offered in the same cycle
      cyc(1'b1, A, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, B, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, C, 1'b1, 1'b1, 1'b0);
      check_empty("flush_full");
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
      check_empty("flush_after");

      // Flush while holding one entry, with a same-cycle accept and pop
      cyc(1'b1, A, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, C, 1'b1, 1'b1, 1'b0);
      check_empty("flush_one");

      // Reset and flush together while full behave as reset, then push 0x5
      cyc(1'b1, A, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, B, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, C, 1'b1, 1'b1, 1'b1);
      check_empty("reset_flush");
      cyc(1'b1, W'(5), 1'b0, 1'b0, 1'b0);
      check("post_reset_valid", W'(out_valid), W'(1));
      check("post_reset_data",  out_data, W'(5));
      check("post_reset_occ",   W'(occupancy), W'(1));

      // Randomized traffic in phases with different valid/ready biases
      for (int phase = 0; phase < 4; phase++) begin
         for (int n = 0; n < 3000; n++) begin
            logic v;
            logic r;
            logic f;
            logic rst;
            case (phase)
               0:       begin v = ($urandom % 4) != 0; r = ($urandom % 4) != 0; end
               1:       begin v = ($urandom % 4) != 0; r = ($urandom % 4) == 0; end
               2:       begin v = ($urandom % 4) == 0; r = ($urandom % 4) != 0; end
               default: begin v = $urandom % 2;        r = $urandom % 2;        end
            endcase
            f   = ($urandom % 64) == 0;
            rst = ($urandom % 512) == 0;
            cyc(v, {$urandom, $urandom}, r, f, rst);
         end
      end

      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
      check_empty("final_drain");

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
